// File: rtl/climate_pkg.sv
// Shared types and constants for the heater/cooler climate controller.
package climate_pkg;

  // Controller states; the encodings are visible on dbg_state.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HEAT  = 3'd1,
    COOL  = 3'd2,
    DEAD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  // Debounced sensor codes built from {T2, T1}.
  localparam logic [1:0] COLD = 2'b00;
  localparam logic [1:0] OK   = 2'b01;
  localparam logic [1:0] BAD  = 2'b10;
  localparam logic [1:0] HOT  = 2'b11;

  // Larger of two bounds, used to size the shared run/fault counters.
  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a joint debounce of the whole vector:
// the accepted value only changes after the synchronised input has disagreed
// with it for DEBOUNCE consecutive cycles.
module sensor_debounce #(
  parameter int               WIDTH    = 2,
  parameter int               DEBOUNCE = 4,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] sens
);

  localparam int             CW   = $clog2(DEBOUNCE) + 1;
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE - 1);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [CW-1:0]    dcnt;

  // Bring the asynchronous raw input into the clock domain.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of the one before it; blocking here would collapse the
    // two synchroniser stages into one.
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end

  // Accept the synchronised value once it has persisted long enough.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sens <= RST_VAL;
      dcnt <= '0;
    end else if (sync_q == sens) begin
      dcnt <= '0;
    end else if (dcnt == LAST) begin
      sens <= sync_q;
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end

endmodule

// File: rtl/climate_controller.sv
// Heater/cooler controller: debounced sensor code drives a Moore FSM that
// enforces mutual exclusion, a minimum run time, a dead time between
// actuators and a latched fault on a persistent inconsistent sensor code.
module climate_controller
  import climate_pkg::*;
#(
  parameter int DEBOUNCE  = 4,
  parameter int MIN_ON    = 8,
  parameter int DEAD_T    = 2,
  parameter int FAULT_CYC = 6
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic [1:0] t_in,
  input  logic       ack,
  output logic       heater,
  output logic       cooler,
  output logic       fault,
  output logic [2:0] dbg_state,
  output logic [1:0] dbg_sens
);

  localparam int            CW         = $clog2(max_of(MIN_ON, max_of(DEAD_T, FAULT_CYC))) + 1;
  localparam logic [CW-1:0] RUN_LAST   = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_T - 1);
  localparam logic [CW-1:0] FAULT_LAST = CW'(FAULT_CYC - 1);

  logic [1:0]    d;
  logic          ack_meta;
  logic          ack_sync;
  state_t        state;
  state_t        state_next;
  logic [CW-1:0] rcnt;
  logic [CW-1:0] rcnt_next;
  logic [CW-1:0] fcnt;
  logic [CW-1:0] fcnt_next;

  sensor_debounce #(
    .WIDTH   (2),
    .DEBOUNCE(DEBOUNCE),
    .RST_VAL (OK)
  ) u_sens (
    .clk  (clk_2),
    .rst_n(reset),
    .raw  (t_in),
    .sens (d)
  );

  // Plain two-flop synchroniser for the acknowledge level.
  always_ff @(posedge clk_2) begin
    if (!reset) begin
      ack_meta <= 1'b0;
      ack_sync <= 1'b0;
    end else begin
      ack_meta <= ack;
      ack_sync <= ack_meta;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_2) begin
    if (!reset) begin
      state <= IDLE;
      rcnt  <= '0;
      fcnt  <= '0;
    end else begin
      state <= state_next;
      rcnt  <= rcnt_next;
      fcnt  <= fcnt_next;
    end
  end

  // Next-state and counter logic; the fault threshold overrides everything.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_next = state;
    rcnt_next  = '0;
    fcnt_next  = '0;

    if (state != FAULT && d == BAD) fcnt_next = fcnt + 1'b1;

    case (state)
      IDLE: begin
        if (d == COLD)     state_next = HEAT;
        else if (d == HOT) state_next = COOL;
      end
      HEAT: begin
        if (rcnt != RUN_LAST)  rcnt_next  = rcnt + 1'b1;
        else if (d != COLD)    state_next = DEAD;
        else                   rcnt_next  = rcnt;
      end
      COOL: begin
        if (rcnt != RUN_LAST)  rcnt_next  = rcnt + 1'b1;
        else if (d != HOT)     state_next = DEAD;
        else                   rcnt_next  = rcnt;
      end
      DEAD: begin
        if (rcnt == DEAD_LAST) state_next = IDLE;
        else                   rcnt_next  = rcnt + 1'b1;
      end
      FAULT: begin
        if (ack_sync && d != BAD) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (d == BAD && fcnt == FAULT_LAST) begin
      state_next = FAULT;
      rcnt_next  = '0;
      fcnt_next  = '0;
    end
  end

  assign heater    = (state == HEAT);
  assign cooler    = (state == COOL);
  assign fault     = (state == FAULT);
  assign dbg_state = state;
  assign dbg_sens  = d;

endmodule

// File: tb/tb_climate_controller.sv
// Bench for climate_controller: a fixed vector table for the reset/heat-up
// sequence, directed multi-cycle scenarios, and randomized stimulus, with
// every edge compared against a cycle-age reference model.
module tb_climate_controller;

  localparam int DEBOUNCE  = 4;
  localparam int MIN_ON    = 8;
  localparam int DEAD_T    = 2;
  localparam int FAULT_CYC = 6;

  // Mode numbers follow the documented dbg_state encoding.
  localparam int M_IDLE = 0, M_HEAT = 1, M_COOL = 2, M_DEAD = 3, M_FAULT = 4;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic [1:0] t_in;
  logic       ack;
  logic       heater, cooler, fault;
  logic [2:0] dbg_state;
  logic [1:0] dbg_sens;

  int vectors     = 0;
  int miscompares = 0;

  climate_controller #(
    .DEBOUNCE (DEBOUNCE),
    .MIN_ON   (MIN_ON),
    .DEAD_T   (DEAD_T),
    .FAULT_CYC(FAULT_CYC)
  ) dut (
    .clk_2    (clk_2),
    .reset    (reset),
    .t_in     (t_in),
    .ack      (ack),
    .heater   (heater),
    .cooler   (cooler),
    .fault    (fault),
    .dbg_state(dbg_state),
    .dbg_sens (dbg_sens)
  );

  always #5 clk_2 = ~clk_2;

  // ---------------- reference model ----------------
  logic [1:0] m_tpipe [2];   // raw sensor delayed by the synchroniser
  logic       m_apipe [2];   // raw ack delayed by the synchroniser
  logic [1:0] m_d;           // accepted sensor code
  int         m_disagree;    // consecutive edges the sync value differed from m_d
  int         m_mode;        // current mode (dbg_state encoding)
  int         m_age;         // full cycles spent in the current mode
  int         m_bad_run;     // consecutive edges with code BAD outside fault

  task automatic model_edge(input logic r, input logic [1:0] t, input logic a);
    int nm;
    if (!r) begin
      m_tpipe[0] = 2'b01; m_tpipe[1] = 2'b01;
      m_apipe[0] = 1'b0;  m_apipe[1] = 1'b0;
      m_d = 2'b01; m_disagree = 0;
      m_mode = M_IDLE; m_age = 0; m_bad_run = 0;
      return;
    end
    nm = m_mode;
    case (m_mode)
      M_IDLE:  if (m_d == 2'b00) nm = M_HEAT; else if (m_d == 2'b11) nm = M_COOL;
      M_HEAT:  if (m_age + 1 >= MIN_ON && m_d != 2'b00) nm = M_DEAD;
      M_COOL:  if (m_age + 1 >= MIN_ON && m_d != 2'b11) nm = M_DEAD;
      M_DEAD:  if (m_age + 1 >= DEAD_T) nm = M_IDLE;
      default: if (m_apipe[1] && m_d != 2'b10) nm = M_IDLE;
    endcase
    if (m_mode != M_FAULT && m_d == 2'b10) m_bad_run++;
    else m_bad_run = 0;
    if (m_bad_run >= FAULT_CYC) begin
      nm = M_FAULT;
      m_bad_run = 0;
    end
    m_age  = (nm == m_mode) ? m_age + 1 : 0;
    m_mode = nm;
    // Sensor path: accept the synchronised code after DEBOUNCE disagreeing edges.
    if (m_tpipe[1] == m_d) m_disagree = 0;
    else begin
      m_disagree++;
      if (m_disagree >= DEBOUNCE) begin
        m_d = m_tpipe[1];
        m_disagree = 0;
      end
    end
    m_tpipe[1] = m_tpipe[0]; m_tpipe[0] = t;
    m_apipe[1] = m_apipe[0]; m_apipe[0] = a;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_outs();
    return {heater, cooler, fault, dbg_state, dbg_sens};
  endfunction

  // Apply one cycle of inputs, advance the model at the edge, compare at negedge.
  task automatic tick(input logic r, input logic [1:0] t, input logic a);
    logic [7:0] exp;
    reset = r; t_in = t; ack = a;
    @(posedge clk_2);
    model_edge(r, t, a);
    @(negedge clk_2);
    exp = {m_mode == M_HEAT, m_mode == M_COOL, m_mode == M_FAULT, 3'(m_mode), m_d};
    check("model", {24'd0, dut_outs()}, {24'd0, exp});
  endtask

  task automatic do_reset();
    tick(1'b0, 2'b01, 1'b0);
    tick(1'b0, 2'b01, 1'b0);
  endtask

  task automatic wait_heater(input logic [1:0] t, output int n);
    n = 0;
    do begin
      tick(1'b1, t, 1'b0);
      n++;
    end while (heater !== 1'b1 && n < 30);
  endtask

  // Starting on the first heater cycle, drive t for 20 cycles and classify them.
  task automatic measure_run(input logic [1:0] t, output int heat_n, output int dead_n,
                             output int idle_n, output int cool_n, output int overlap);
    heat_n = 1; dead_n = 0; idle_n = 0; cool_n = 0; overlap = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, t, 1'b0);
      if (heater) heat_n++;
      if (cooler) cool_n++;
      if (heater && cooler) overlap++;
      if (dbg_state == 3'd3) dead_n++;
      if (dbg_state == 3'd0 && cool_n == 0) idle_n++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [1:0] t;
    logic       a;
    logic [7:0] exp;   // {heater, cooler, fault, dbg_state, dbg_sens}
  } vec_t;

  vec_t tbl [11];
  int   n, heat_n, dead_n, idle_n, cool_n, overlap, bad_cnt;
  logic [1:0] r_code;
  int   r_len;
  logic r_rst;

  initial begin
    reset = 1'b0; t_in = 2'b01; ack = 1'b0;

    // Reset for three edges, then COLD held: d at edge 6, heater at edge 7.
    tbl[0]  = '{1'b0, 2'b00, 1'b0, 8'b000_000_01};
    tbl[1]  = '{1'b0, 2'b00, 1'b0, 8'b000_000_01};
    tbl[2]  = '{1'b0, 2'b00, 1'b0, 8'b000_000_01};
    tbl[3]  = '{1'b1, 2'b00, 1'b0, 8'b000_000_01};
    tbl[4]  = '{1'b1, 2'b00, 1'b0, 8'b000_000_01};
    tbl[5]  = '{1'b1, 2'b00, 1'b0, 8'b000_000_01};
    tbl[6]  = '{1'b1, 2'b00, 1'b0, 8'b000_000_01};
    tbl[7]  = '{1'b1, 2'b00, 1'b0, 8'b000_000_01};
    tbl[8]  = '{1'b1, 2'b00, 1'b0, 8'b000_000_00};
    tbl[9]  = '{1'b1, 2'b00, 1'b0, 8'b100_001_00};
    tbl[10] = '{1'b1, 2'b00, 1'b0, 8'b100_001_00};
    for (int i = 0; i < 11; i++) begin
      tick(tbl[i].rst, tbl[i].t, tbl[i].a);
      check($sformatf("table[%0d]", i), {24'd0, dut_outs()}, {24'd0, tbl[i].exp});
    end

    // Three-cycle COLD glitch in IDLE is rejected.
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 2'b01, 1'b0);
    bad_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      tick(1'b1, (i < 3) ? 2'b00 : 2'b01, 1'b0);
      if (heater || dbg_state != 3'd0 || dbg_sens != 2'b01) bad_cnt++;
    end
    check("glitch_rejected", bad_cnt, 0);

    // Heater released right after turn-on: MIN_ON cycles, DEAD_T off, IDLE.
    do_reset();
    wait_heater(2'b00, n);
    check("heat_latency", n, 7);
    measure_run(2'b01, heat_n, dead_n, idle_n, cool_n, overlap);
    check("min_on_heat", heat_n, MIN_ON);
    check("dead_time", dead_n, DEAD_T);
    check("back_to_idle", {29'd0, dbg_state}, 0);
    check("no_cooler", cool_n, 0);

    // COLD -> HOT while heating: no direct HEAT->COOL path.
    do_reset();
    wait_heater(2'b00, n);
    measure_run(2'b11, heat_n, dead_n, idle_n, cool_n, overlap);
    check("swap_heat_len", heat_n, MIN_ON);
    check("swap_dead_len", dead_n, DEAD_T);
    check("swap_idle_len", idle_n, 1);
    check("swap_cooler_on", {31'd0, cool_n != 0}, 1);
    check("swap_overlap", overlap, 0);

    // Persistent BAD code latches a fault; ack only clears it once code is good.
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 2'b01, 1'b0);
    n = 0;
    do begin tick(1'b1, 2'b10, 1'b0); n++; end while (dbg_sens !== 2'b10 && n < 30);
    check("bad_debounce", n, 6);
    n = 0;
    do begin tick(1'b1, 2'b10, 1'b0); n++; end while (fault !== 1'b1 && n < 30);
    check("fault_delay", n, FAULT_CYC);
    check("fault_actuators_off", {30'd0, heater, cooler}, 0);
    bad_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 2'b10, 1'b1);
      if (!fault) bad_cnt++;
    end
    check("ack_while_bad", bad_cnt, 0);
    n = 0;
    do begin tick(1'b1, 2'b01, 1'b0); n++; end while (dbg_sens !== 2'b01 && n < 30);
    check("fault_held_until_ack", {31'd0, fault}, 1);
    n = 0;
    do begin tick(1'b1, 2'b01, 1'b1); n++; end while (fault !== 1'b0 && n < 30);
    check("ack_exit_edges", n, 3);
    check("ack_exit_state", {29'd0, dbg_state}, 0);

    // Reset mid-HEAT drops to IDLE and a new COLD restarts the full MIN_ON.
    do_reset();
    wait_heater(2'b00, n);
    for (int i = 0; i < 4; i++) tick(1'b1, 2'b00, 1'b0);
    check("heater_before_reset", {31'd0, heater}, 1);
    tick(1'b0, 2'b00, 1'b0);
    check("reset_mid_heat", {24'd0, heater, cooler, fault, dbg_state, 2'b00}, 0);
    wait_heater(2'b00, n);
    check("restart_latency", n, 7);
    measure_run(2'b01, heat_n, dead_n, idle_n, cool_n, overlap);
    check("restart_min_on", heat_n, MIN_ON);

    // Randomized segments against the reference model.
    do_reset();
    for (int seg = 0; seg < 300; seg++) begin
      r_code = 2'($urandom_range(0, 3));
      r_len  = $urandom_range(1, 14);
      r_rst  = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < r_len; k++)
        tick(!(r_rst && k == 0), r_code, ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/climate_controller.md
Name: climate_controller

Overview:
- Sequential controller for the board's heater/cooler resource, driven by sensor switches T1/T2.
- Pipeline: synchronises and debounces both sensor bits, then runs an FSM with the following rules:
  - heater and cooler are mutually exclusive.
  - each has a minimum run time.
  - a dead time separates heater and cooler.
  - an inconsistent sensor code held long enough latches a fault.
- Instantiated by top: switches feed t_in and ack; heater, cooler and fault drive LEDs/SEG; dbg_state drives the LCD.

Parameters:
DEBOUNCE, 4, consecutive cycles a new sensor value must persist before acceptance (>=3)
MIN_ON, 8, minimum cycles spent in HEAT or COOL (>=1)
DEAD_T, 2, cycles with both actuators off after HEAT/COOL (>=1)
FAULT_CYC, 6, cycles the debounced code must be "bad" before FAULT (>=1)

Ports:
clk_2  in  1  system clock; all state on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
t_in  in  2  raw sensors; t_in[0]=T1, t_in[1]=T2
ack  in  1  fault acknowledge, level, asynchronous source
heater  out  1  heater enable
cooler  out  1  cooler enable
fault  out  1  fault latched
dbg_state  out  3  encoded FSM state
dbg_sens  out  2  debounced sensor code

Behaviour:
- Sensor codes after debounce (d):
  - COLD=2'b00
  - OK=2'b01
  - BAD=2'b10
  - HOT=2'b11
- Reset (reset==0 at an edge) forces the following; all have priority over all other logic:
  - state=IDLE
  - heater=cooler=fault=0
  - sync stages and d = OK
  - all counters = 0
- Input path:
  - t_in and ack each pass through a 2-flop synchroniser; the sync stage output is s.
  - Debounce rule:
    - if s==d, dcnt<=0.
    - else if dcnt==DEBOUNCE-1, then d<=s and dcnt<=0.
    - else dcnt<=dcnt+1.
  - The 2-bit vector is debounced jointly.
- Latency: a stable t_in change sampled at edge 1 reaches d at edge DEBOUNCE+2 and the actuator outputs at edge DEBOUNCE+3 (7 with defaults).
- Outputs are Moore, decoded from the registered state:
  - heater=(state==HEAT)
  - cooler=(state==COOL)
  - fault=(state==FAULT)
- State encoding: IDLE=0, HEAT=1, COOL=2, DEAD=3, FAULT=4.
- Fault counter fcnt:
  - increments while d==BAD and state!=FAULT.
  - cleared otherwise.
  - when d==BAD and fcnt==FAULT_CYC-1, next state is FAULT from any state; this overrides all transitions below.
- IDLE:
  - d==COLD -> HEAT.
  - d==HOT -> COOL.
  - otherwise stay.
  - run counter rcnt cleared.
- HEAT:
  - rcnt increments, saturating at MIN_ON-1.
  - when rcnt==MIN_ON-1 and d!=COLD -> DEAD, rcnt<=0.
  - d leaving COLD before MIN_ON has elapsed is ignored until the minimum is met.
- COOL: identical to HEAT with HOT in place of COLD.
- DEAD:
  - rcnt increments.
  - when rcnt==DEAD_T-1 -> IDLE, rcnt<=0.
  - there is no direct HEAT<->COOL path; IDLE evaluates d on the following edge.
- FAULT:
  - all actuators off.
  - exit to IDLE only when the synchronised ack==1 and d!=BAD; otherwise stay.
  - ack outside FAULT is ignored.
- Invariants:
  - heater&cooler never both 1.
  - any actuator turn-on is preceded by at least DEAD_T off-cycles after the other actuator turns off.
- Simultaneous events:
  - the fault threshold and a MIN_ON expiry on the same edge -> FAULT.
  - reset asserted mid-HEAT/COOL/DEAD/FAULT -> IDLE on that edge with outputs 0; no resume.
- Counter widths are $clog2 of the largest bound plus one; no wrap-around is reachable.

Decomposition:
- Package climate_pkg:
  - state_t enum (3-bit, encodings above).
  - sensor code localparams COLD/OK/BAD/HOT.
- Sub-module sensor_debounce holds the 2-flop sync plus the joint debounce counter:
  - parameters WIDTH and DEBOUNCE.
  - reset value port/parameter RST_VAL.
  - reused for t_in; ack uses only a plain 2-flop sync.

Test Plan:
1. reset=0 for 3 edges, then reset=1, t_in=00 held -> heater=0,cooler=0,fault=0,dbg_state=0 until edge 7 after release; heater=1 from edge 7.
2. Idle at t_in=01, pulse t_in=00 for 3 cycles, then back to 01 -> d stays 01, heater never 1, dbg_state stays 0.
3. Heater just asserted, t_in->01 on the next cycle -> heater holds for exactly 8 cycles total, then 2 cycles of heater=cooler=0 (state 3), then state 0.
4. In HEAT, t_in 00->11 held -> heater completes MIN_ON, DEAD for 2 cycles, IDLE for 1 cycle, then cooler=1; heater&cooler is never 1 on any cycle.
5. t_in=10 held -> d=10 after 6 edges, fault=1 six edges later, actuators 0; ack=1 with t_in=10 -> no exit; t_in=01 until d=01, then ack=1 -> fault=0 and state 0 two edges after ack rises.
6. reset=0 asserted for one edge while heater=1 and rcnt=4 -> heater=0 and dbg_state=0 after that edge; a later COLD restarts the full MIN_ON count.
